// File: rtl/snpu_host_link_if.sv
// Pin-side bundle of the SNPU host link: the Tiny Tapeout byte pins and
// the bidirectional pin group carrying req/ack/rsp_valid/err.
interface snpu_host_link_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // The external tester drives the command byte and req
    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    // The tile terminates the protocol and drives the response pins
    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/snpu_host_link.sv
// Device-side four-phase req/ack byte protocol engine for the SNPU tile.
// Captures command bytes from the pins, decodes them into core register
// writes, reads, start pulses and status queries, and returns responses.
module snpu_host_link #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    snpu_host_link_if.slave   pins,
    output logic              core_wr_en,
    output logic [3:0]        core_wr_addr,
    output logic [7:0]        core_wr_data,
    output logic [3:0]        core_rd_addr,
    input  logic [7:0]        core_rd_data,
    output logic              core_start,
    input  logic              core_busy
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } state_t;

    state_t          state, next_state;
    logic [SS-1:0]   sync_q;
    logic [SS-1:0]   fill_q;
    logic            req_s;
    logic            ack;
    logic            armed;
    logic            capture;
    logic            rsp_valid;
    logic            err;
    logic [7:0]      resp_byte;
    logic [3:0]      addr_q;
    logic [TW-1:0]   tcount;
    logic            read_pend;
    logic            stat_pend;

    logic            do_write;
    logic            do_start;
    logic            do_read;
    logic            do_status;
    logic            set_err;
    logic            clr_err;
    logic            enter_wdata;

    logic            unused_uio;

    assign unused_uio = ^pins.uio_in[7:1];

    assign req_s   = sync_q[SS-1];
    assign capture = req_s && !ack && armed && ena;

    assign pins.uo_out  = resp_byte;
    assign pins.uio_out = {4'b0000, err, rsp_valid, ack, 1'b0};
    assign pins.uio_oe  = 8'b0000_1110;

    // Synchronize req; fill_q marks when the chain holds real pin samples,
    // so the reset zeros are not mistaken for the host having dropped req
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SS-2:0], pins.uio_in[0]};
            fill_q <= {fill_q[SS-2:0], 1'b1};
        end
    end

    // Handshake: capture raises ack and disarms; req low re-arms and drops ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack   <= 1'b0;
            armed <= 1'b0;
        end else if (capture) begin
            ack   <= 1'b1;
            armed <= 1'b0;
        end else begin
            if (!req_s && fill_q[SS-1]) begin
                armed <= 1'b1;
            end
            if (ack && !req_s) begin
                ack <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Opcode decode, data-byte handling and WDATA timeout
    always_comb begin
        next_state  = state;
        do_write    = 1'b0;
        do_start    = 1'b0;
        do_read     = 1'b0;
        do_status   = 1'b0;
        set_err     = 1'b0;
        clr_err     = 1'b0;
        enter_wdata = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    if (pins.ui_in[7:4] == 4'h1) begin
                        next_state  = WDATA;
                        enter_wdata = 1'b1;
                    end else if (pins.ui_in[7:4] == 4'h2) begin
                        do_read = 1'b1;
                    end else if (pins.ui_in == 8'h30) begin
                        if (core_busy) begin
                            set_err = 1'b1;
                        end else begin
                            do_start = 1'b1;
                        end
                    end else if (pins.ui_in == 8'h40) begin
                        do_status = 1'b1;
                    end else if (pins.ui_in == 8'h50) begin
                        clr_err = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            WDATA: begin
                if (capture) begin
                    do_write   = 1'b1;
                    next_state = IDLE;
                end else if (TIMEOUT_EN && tcount == TLIMIT) begin
                    set_err    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // WDATA watchdog counter, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcount <= '0;
        end else if (enter_wdata) begin
            tcount <= '0;
        end else if (state == WDATA && tcount != TLIMIT) begin
            tcount <= tcount + 1'b1;
        end
    end

    // Core-facing strobes, addresses and write data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_wr_en   <= 1'b0;
            core_start   <= 1'b0;
            core_wr_addr <= 4'h0;
            core_wr_data <= 8'h00;
            core_rd_addr <= 4'h0;
            addr_q       <= 4'h0;
        end else begin
            core_wr_en <= do_write;
            core_start <= do_start;
            if (enter_wdata) begin
                addr_q <= pins.ui_in[3:0];
            end
            if (do_write) begin
                core_wr_addr <= addr_q;
                core_wr_data <= pins.ui_in;
            end
            if (do_read) begin
                core_rd_addr <= pins.ui_in[3:0];
            end
        end
    end

    // Response byte, rsp_valid and the sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_pend <= 1'b0;
            stat_pend <= 1'b0;
            rsp_valid <= 1'b0;
            resp_byte <= 8'h00;
            err       <= 1'b0;
        end else begin
            read_pend <= do_read;
            stat_pend <= do_status;
            if (capture) begin
                rsp_valid <= 1'b0;
            end else if (read_pend || stat_pend) begin
                rsp_valid <= 1'b1;
            end
            if (read_pend) begin
                resp_byte <= core_rd_data;
            end else if (stat_pend) begin
                resp_byte <= {core_busy, err, 6'b000000};
            end
            if (set_err) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_snpu_host_link.sv
// Self-checking bench for snpu_host_link: directed protocol scenarios plus
// a randomized command stream checked against a transaction-level model.
module tb_snpu_host_link;

    localparam int TOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       core_busy = 1'b0;
    logic       core_wr_en;
    logic [3:0] core_wr_addr;
    logic [7:0] core_wr_data;
    logic [3:0] core_rd_addr;
    logic [7:0] core_rd_data;
    logic       core_start;

    snpu_host_link_if pins();

    snpu_host_link #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .pins         (pins),
        .core_wr_en   (core_wr_en),
        .core_wr_addr (core_wr_addr),
        .core_wr_data (core_wr_data),
        .core_rd_addr (core_rd_addr),
        .core_rd_data (core_rd_data),
        .core_start   (core_start),
        .core_busy    (core_busy)
    );

    always #5 clk = ~clk;

    // Simple core register file behind the link
    logic [7:0] core_regs [16];
    assign core_rd_data = core_regs[core_rd_addr];
    always @(posedge clk) begin
        if (core_wr_en) core_regs[core_wr_addr] <= core_wr_data;
    end

    // Strobe monitor
    int          got_wr_cnt = 0;
    int          got_start_cnt = 0;
    logic [11:0] got_last_wr = '0;
    always @(negedge clk) begin
        if (core_wr_en) begin
            got_wr_cnt++;
            got_last_wr = {core_wr_addr, core_wr_data};
        end
        if (core_start) got_start_cnt++;
    end

    // Transaction-level reference model
    bit          m_wdata = 0;
    logic [3:0]  m_addr = '0;
    logic        m_err = 0;
    logic [7:0]  m_uo = '0;
    logic        m_rsp = 0;
    logic [7:0]  ref_regs [16];
    int          exp_wr_cnt = 0;
    int          exp_start_cnt = 0;
    logic [11:0] exp_last_wr = '0;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_wdata = 0;
        m_err   = 0;
        m_uo    = 8'h00;
        m_rsp   = 0;
    endtask

    task automatic modelByte(input logic [7:0] b, input logic busy);
        m_rsp = 0;
        if (m_wdata) begin
            m_wdata = 0;
            ref_regs[m_addr] = b;
            exp_wr_cnt++;
            exp_last_wr = {m_addr, b};
        end else if (b[7:4] == 4'h1) begin
            m_wdata = 1;
            m_addr  = b[3:0];
        end else if (b[7:4] == 4'h2) begin
            m_uo  = ref_regs[b[3:0]];
            m_rsp = 1;
        end else if (b == 8'h30) begin
            if (busy) m_err = 1;
            else exp_start_cnt++;
        end else if (b == 8'h40) begin
            m_uo  = {busy, m_err, 6'b0};
            m_rsp = 1;
        end else if (b == 8'h50) begin
            m_err = 0;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic compareModel(input string tag);
        checkOutput({tag, "_uo"},     pins.uo_out, m_uo);
        checkOutput({tag, "_rsp"},    pins.uio_out[2], m_rsp);
        checkOutput({tag, "_err"},    pins.uio_out[3], m_err);
        checkOutput({tag, "_wrcnt"},  got_wr_cnt, exp_wr_cnt);
        checkOutput({tag, "_stcnt"},  got_start_cnt, exp_start_cnt);
        checkOutput({tag, "_lastwr"}, got_last_wr, exp_last_wr);
    endtask

    // Completes a byte whose req is already high: wait ack, check, drop req
    task automatic finishByte(input logic [7:0] b, input logic busy, input bit check_lat, input string tag);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (pins.uio_out[1] !== 1'b1 && waited < 30);
        checkOutput({tag, "_ack_rise"}, pins.uio_out[1], 1'b1);
        if (check_lat) checkOutput({tag, "_ack_lat"}, waited, 3);
        checkOutput({tag, "_rsp_clr"}, pins.uio_out[2], 1'b0);
        modelByte(b, busy);
        @(negedge clk);
        #1;
        compareModel(tag);
        pins.uio_in = 8'h00;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (pins.uio_out[1] !== 1'b0 && waited < 30);
        checkOutput({tag, "_ack_fall"}, pins.uio_out[1], 1'b0);
        if (check_lat) checkOutput({tag, "_ackf_lat"}, waited, 3);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic busy, input string tag);
        @(negedge clk);
        pins.ui_in  = b;
        pins.uio_in = 8'h01;
        core_busy   = busy;
        finishByte(b, busy, 1'b1, tag);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int op;
        logic [7:0] rb;
        for (int i = 0; i < 16; i++) begin
            core_regs[i] = 8'h00;
            ref_regs[i]  = 8'h00;
        end
        pins.ui_in  = 8'h00;
        pins.uio_in = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_uo",     pins.uo_out, 8'h00);
        checkOutput("rst_uio",    pins.uio_out, 8'h00);
        checkOutput("rst_oe",     pins.uio_oe, 8'h0E);
        checkOutput("rst_wr_en",  core_wr_en, 1'b0);
        checkOutput("rst_start",  core_start, 1'b0);
        checkOutput("rst_rdaddr", core_rd_addr, 4'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write then read
        applyStimulus(8'h13, 1'b0, "wr_op");
        applyStimulus(8'hA5, 1'b0, "wr_data");
        checkOutput("wr_addr3", got_last_wr, 12'h3A5);
        applyStimulus(8'h23, 1'b0, "rd3");
        checkOutput("rd3_val", pins.uo_out, 8'hA5);

        // Start and busy
        applyStimulus(8'h30, 1'b0, "start_ok");
        applyStimulus(8'h30, 1'b1, "start_busy");
        applyStimulus(8'h40, 1'b1, "status1");
        checkOutput("status_c0", pins.uo_out, 8'hC0);
        applyStimulus(8'h50, 1'b1, "clr1");
        applyStimulus(8'h40, 1'b1, "status2");
        checkOutput("status_80", pins.uo_out, 8'h80);

        // Timeout in WDATA
        applyStimulus(8'h17, 1'b0, "to_op");
        repeat (20) @(negedge clk);
        m_wdata = 0;
        m_err   = 1;
        #1;
        checkOutput("to_err", pins.uio_out[3], 1'b1);
        checkOutput("to_nowr", got_wr_cnt, exp_wr_cnt);
        applyStimulus(8'h23, 1'b0, "to_rd");

        // Illegal opcode
        applyStimulus(8'hFF, 1'b0, "illegal");
        applyStimulus(8'h50, 1'b0, "clr2");
        checkOutput("clr2_err", pins.uio_out[3], 1'b0);

        // Reset mid-handshake with req held high through release
        @(negedge clk);
        pins.ui_in  = 8'hFF;
        pins.uio_in = 8'h01;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (pins.uio_out[1] !== 1'b1 && waited < 30);
        checkOutput("rs_ack_lat", waited, 3);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rs_uio", pins.uio_out, 8'h00);
        checkOutput("rs_uo",  pins.uo_out, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("rs_held_ack", pins.uio_out[1], 1'b0);
        checkOutput("rs_held_err", pins.uio_out[3], 1'b0);
        pins.uio_in = 8'h00;
        repeat (5) @(negedge clk);
        applyStimulus(8'h40, 1'b0, "rs_after");

        // ena gating
        ena = 1'b0;
        @(negedge clk);
        pins.ui_in  = 8'h40;
        pins.uio_in = 8'h01;
        core_busy   = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("ena_gated_ack", pins.uio_out[1], 1'b0);
        ena = 1'b1;
        finishByte(8'h40, 1'b1, 1'b0, "ena_on");

        // Randomized command stream
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 8);
            case (op)
                0, 1, 2: begin
                    applyStimulus({4'h1, 4'($urandom_range(0, 15))}, 1'($urandom_range(0, 1)), "r_wop");
                    applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "r_wdat");
                end
                3, 4: applyStimulus({4'h2, 4'($urandom_range(0, 15))}, 1'($urandom_range(0, 1)), "r_rd");
                5: applyStimulus(8'h30, 1'($urandom_range(0, 1)), "r_start");
                6: applyStimulus(8'h40, 1'($urandom_range(0, 1)), "r_stat");
                7: applyStimulus(8'h50, 1'($urandom_range(0, 1)), "r_clr");
                default: begin
                    rb = 8'($urandom_range(0, 255));
                    applyStimulus(rb, 1'($urandom_range(0, 1)), "r_any");
                end
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
